// File: rtl/scalar_mul_pkg.sv
// Shared types and constants for the scalar-multiply RAM datapath:
// word width, operand stride, FSM encoding, transfer directions, operand bases.
package scalar_mul_pkg;

  localparam int DATA_W_DEF            = 64;
  localparam int WORDS_PER_OPERAND_DEF = 3;
  localparam int ADDR_W                = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_t;

  localparam logic DIR_OUTER_TO_INNER = 1'b0;
  localparam logic DIR_INNER_TO_OUTER = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_X1 = 6'd3;
  localparam logic [ADDR_W-1:0] ADDR_Y1 = 6'd6;
  localparam logic [ADDR_W-1:0] ADDR_A  = 6'd9;
  localparam logic [ADDR_W-1:0] ADDR_PX = 6'h21;
  localparam logic [ADDR_W-1:0] ADDR_PY = 6'h27;

  // True when a whole operand starting at base fits without wrapping.
  function automatic logic base_in_range(
    input logic [ADDR_W-1:0] base,
    input int                words
  );
    return int'(base) <= (1 << ADDR_W) - words;
  endfunction

endpackage

// File: rtl/ram_transfer_engine.sv
// Copies one operand (WORDS_PER_OPERAND words) between outer and inner RAM.
// Ports: clk, rst (sync, active-high); cmd_transfer, read_write_command,
//   read_address, write_address (command); interupt_ram_transfer, xfer_error,
//   busy (status); outer_* and inner_* RAM ports (1-cycle read latency).
// Build option: SCALAR_MUL_RAM_RANGE_CHECK_EN rejects operands that would wrap.
module ram_transfer_engine
  import scalar_mul_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int WORDS_PER_OPERAND = WORDS_PER_OPERAND_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_transfer,
  input  logic              read_write_command,
  input  logic [5:0]        read_address,
  input  logic [5:0]        write_address,
  output logic              interupt_ram_transfer,
  output logic              xfer_error,
  output logic              busy,
  output logic [5:0]        outer_addr,
  output logic              outer_rd_en,
  input  logic [DATA_W-1:0] outer_rdata,
  output logic              outer_wr_en,
  output logic [DATA_W-1:0] outer_wdata,
  output logic [5:0]        inner_addr,
  output logic              inner_rd_en,
  input  logic [DATA_W-1:0] inner_rdata,
  output logic              inner_wr_en,
  output logic [DATA_W-1:0] inner_wdata
);

  localparam int CNT_W = $clog2(WORDS_PER_OPERAND + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_OPERAND);

  xfer_state_t       state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept;
  logic              dir_q;
  logic [ADDR_W-1:0] src_base, dst_base;

  logic              rd_act, wr_act;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [DATA_W-1:0] src_rdata;

  logic [ADDR_W-1:0] outer_addr_q, inner_addr_q;
  logic [DATA_W-1:0] outer_wdata_q, inner_wdata_q;

`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
  logic err_q, err_nx, bad_cmd;

  assign bad_cmd =
    !base_in_range(read_address, WORDS_PER_OPERAND) ||
    !base_in_range(write_address, WORDS_PER_OPERAND);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
    err_nx   = err_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (cmd_transfer) begin
          accept = 1'b1;
          cnt_nx = '0;
`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
          err_nx   = bad_cmd;
          state_nx = bad_cmd ? ST_DONE : ST_XFER;
`else
          state_nx = ST_XFER;
`endif
        end
      end
      // cnt runs 0..N: reads on 0..N-1, writes trail by one on 1..N.
      ST_XFER: begin
        if (cnt == LAST) state_nx = ST_DONE;
        else             cnt_nx   = cnt + 1'b1;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dir_q    <= DIR_OUTER_TO_INNER;
      src_base <= '0;
      dst_base <= '0;
`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
      err_q <= err_nx;
`endif
      if (accept) begin
        dir_q    <= read_write_command;
        src_base <= read_address;
        dst_base <= write_address;
      end
    end
  end

  assign rd_act    = (state == ST_XFER) && (cnt != LAST);
  assign wr_act    = (state == ST_XFER) && (cnt != '0);
  assign src_addr  = src_base + ADDR_W'(cnt);
  assign dst_addr  = dst_base + ADDR_W'(cnt) - ADDR_W'(1);
  assign src_rdata = (dir_q == DIR_INNER_TO_OUTER) ? inner_rdata : outer_rdata;

  // Idle ports replay the last driven address/data from the hold registers.
  always_comb begin
    outer_rd_en = rd_act && (dir_q == DIR_OUTER_TO_INNER);
    outer_wr_en = wr_act && (dir_q == DIR_INNER_TO_OUTER);
    inner_rd_en = rd_act && (dir_q == DIR_INNER_TO_OUTER);
    inner_wr_en = wr_act && (dir_q == DIR_OUTER_TO_INNER);

    outer_addr = outer_addr_q;
    if (outer_rd_en) outer_addr = src_addr;
    if (outer_wr_en) outer_addr = dst_addr;

    inner_addr = inner_addr_q;
    if (inner_rd_en) inner_addr = src_addr;
    if (inner_wr_en) inner_addr = dst_addr;

    outer_wdata = outer_wr_en ? src_rdata : outer_wdata_q;
    inner_wdata = inner_wr_en ? src_rdata : inner_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outer_addr_q  <= '0;
      inner_addr_q  <= '0;
      outer_wdata_q <= '0;
      inner_wdata_q <= '0;
    end else begin
      outer_addr_q  <= outer_addr;
      inner_addr_q  <= inner_addr;
      outer_wdata_q <= outer_wdata;
      inner_wdata_q <= inner_wdata;
    end
  end

  assign busy                  = (state != ST_IDLE);
  assign interupt_ram_transfer = (state == ST_DONE);
`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
  assign xfer_error            = (state == ST_DONE) && err_q;
`else
  assign xfer_error            = 1'b0;
`endif

endmodule

// File: tb/tb_ram_transfer_engine.sv
// Self-checking bench for ram_transfer_engine: RAM models, access monitor,
// directed scenarios plus random commands against an array-copy model.
module tb_ram_transfer_engine;
  import scalar_mul_pkg::*;

  localparam int DW = 64;
  localparam int N  = WORDS_PER_OPERAND_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_transfer = 1'b0;
  logic          read_write_command = 1'b0;
  logic [5:0]    read_address = '0;
  logic [5:0]    write_address = '0;
  logic          interupt_ram_transfer, xfer_error, busy;
  logic [5:0]    outer_addr, inner_addr;
  logic          outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en;
  logic [DW-1:0] outer_rdata = '0;
  logic [DW-1:0] inner_rdata = '0;
  logic [DW-1:0] outer_wdata, inner_wdata;

  always #5 clk = ~clk;

  ram_transfer_engine #(.DATA_W(DW), .WORDS_PER_OPERAND(N)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_transfer          (cmd_transfer),
    .read_write_command    (read_write_command),
    .read_address          (read_address),
    .write_address         (write_address),
    .interupt_ram_transfer (interupt_ram_transfer),
    .xfer_error            (xfer_error),
    .busy                  (busy),
    .outer_addr            (outer_addr),
    .outer_rd_en           (outer_rd_en),
    .outer_rdata           (outer_rdata),
    .outer_wr_en           (outer_wr_en),
    .outer_wdata           (outer_wdata),
    .inner_addr            (inner_addr),
    .inner_rd_en           (inner_rd_en),
    .inner_rdata           (inner_rdata),
    .inner_wr_en           (inner_wr_en),
    .inner_wdata           (inner_wdata)
  );

  logic [DW-1:0] omem [64];
  logic [DW-1:0] imem [64];
  logic [DW-1:0] m_outer [64];
  logic [DW-1:0] m_inner [64];

  logic          bd_we = 1'b0;
  logic          bd_sel = 1'b0;
  logic [5:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
    if (bd_we && !bd_sel) omem[bd_addr] <= bd_data;
    if (bd_we &&  bd_sel) imem[bd_addr] <= bd_data;
    if (outer_rd_en) outer_rdata <= omem[outer_addr];
    if (outer_wr_en) omem[outer_addr] <= outer_wdata;
    if (inner_rd_en) inner_rdata <= imem[inner_addr];
    if (inner_wr_en) imem[inner_addr] <= inner_wdata;
  end

  bit mon_on = 1'b0;
  int n_ord = 0, n_owr = 0, n_ird = 0, n_iwr = 0;
  int n_irq = 0, n_err = 0, n_same = 0, n_hold = 0;
  logic [5:0]    p_oaddr, p_iaddr;
  logic [DW-1:0] p_owd, p_iwd;

  always @(negedge clk) begin
    if (mon_on) begin
      if (outer_rd_en) n_ord++;
      if (outer_wr_en) n_owr++;
      if (inner_rd_en) n_ird++;
      if (inner_wr_en) n_iwr++;
      if (interupt_ram_transfer) n_irq++;
      if (xfer_error) n_err++;
      if ((outer_rd_en && outer_wr_en) || (inner_rd_en && inner_wr_en))
        n_same++;
      if (!rst_at_edge) begin
        if (!outer_rd_en && !outer_wr_en && outer_addr !== p_oaddr) n_hold++;
        if (!inner_rd_en && !inner_wr_en && inner_addr !== p_iaddr) n_hold++;
        if (!outer_wr_en && outer_wdata !== p_owd) n_hold++;
        if (!inner_wr_en && inner_wdata !== p_iwd) n_hold++;
      end
    end
    p_oaddr = outer_addr;
    p_iaddr = inner_addr;
    p_owd   = outer_wdata;
    p_iwd   = inner_wdata;
  end

  int n_chk = 0, n_fail = 0;
  int b_ord, b_owr, b_ird, b_iwr, b_irq, b_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit range_ok(input int ra, input int wa);
`ifdef SCALAR_MUL_RAM_RANGE_CHECK_EN
    return (ra <= 64 - N) && (wa <= 64 - N);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_cmd(input bit d, input int ra, input int wa,
                                    input int nw);
    for (int k = 0; k < nw; k++) begin
      if (d) m_outer[(wa + k) % 64] = m_inner[(ra + k) % 64];
      else   m_inner[(wa + k) % 64] = m_outer[(ra + k) % 64];
    end
  endfunction

  function automatic int mem_diffs();
    int c = 0;
    for (int i = 0; i < 64; i++) begin
      if (omem[i] !== m_outer[i]) c++;
      if (imem[i] !== m_inner[i]) c++;
    end
    return c;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_ord = n_ord; b_owr = n_owr; b_ird = n_ird; b_iwr = n_iwr;
    b_irq = n_irq; b_err = n_err;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_irq"}, interupt_ram_transfer, 0);
    chk({tag, "_err"}, xfer_error, 0);
    chk({tag, "_en"},
        {outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en}, 0);
    chk({tag, "_oaddr"}, outer_addr, 0);
    chk({tag, "_iaddr"}, inner_addr, 0);
    chk({tag, "_owd"}, outer_wdata, 0);
    chk({tag, "_iwd"}, inner_wdata, 0);
  endtask

  task automatic run_cmd(input bit d, input int ra, input int wa,
                         output int acc);
    sync();
    snap();
    @(negedge clk);
    cmd_transfer       = 1'b1;
    read_write_command = d;
    read_address       = 6'(ra);
    write_address      = 6'(wa);
    @(negedge clk);
    cmd_transfer = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_pulse(output int pc, output bit found, output logic e);
    pc = -1; found = 1'b0; e = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (interupt_ram_transfer === 1'b1) begin
        pc = cyc; found = 1'b1; e = xfer_error;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_counts(input string tag, input bit d, input int nrd,
                            input int nwr, input int nirq);
    int srd, dwr, wrong;
    srd   = d ? n_ird - b_ird : n_ord - b_ord;
    dwr   = d ? n_owr - b_owr : n_iwr - b_iwr;
    wrong = d ? (n_ord - b_ord) + (n_iwr - b_iwr)
              : (n_ird - b_ird) + (n_owr - b_owr);
    chk({tag, "_src_rd"}, srd, nrd);
    chk({tag, "_dst_wr"}, dwr, nwr);
    chk({tag, "_wrong_side"}, wrong, 0);
    chk({tag, "_irq_cnt"}, n_irq - b_irq, nirq);
  endtask

  task automatic do_cmd(input string tag, input bit d, input int ra,
                        input int wa);
    int acc, pc;
    bit ok, found;
    logic e;
    ok = range_ok(ra, wa);
    run_cmd(d, ra, wa, acc);
    chk({tag, "_busy"}, busy, ok);
    wait_pulse(pc, found, e);
    chk({tag, "_irq_seen"}, found, 1);
    chk({tag, "_irq_lat"}, pc - acc, ok ? N + 1 : 0);
    chk({tag, "_xerr"}, e, !ok);
    sync();
    if (ok) model_cmd(d, ra, wa, N);
    chk({tag, "_mem"}, mem_diffs(), 0);
    chk_counts(tag, d, ok ? N : 0, ok ? N : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, pc, pc1, pc2;
    bit found;
    logic e;

    // Reset held with a pending command: command must not win.
    rst = 1'b1;
    cmd_transfer = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) begin
        logic [DW-1:0] v;
        v = {$urandom, $urandom};
        @(negedge clk);
        bd_we = 1'b1; bd_sel = s[0]; bd_addr = 6'(i); bd_data = v;
        if (s == 0) m_outer[i] = v;
        else        m_inner[i] = v;
      end
    end
    @(negedge clk);
    bd_we = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    cmd_transfer = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", busy, 0);
    chk("preload_mem", mem_diffs(), 0);
    mon_on = 1'b1;

    // Outer X1 operand into inner X1.
    do_cmd("o2i_x1", DIR_OUTER_TO_INNER, ADDR_X1, ADDR_X1);

    // Inner PX operand back to outer PX.
    do_cmd("i2o_px", DIR_INNER_TO_OUTER, ADDR_PX, ADDR_PX);

    // Back-to-back: second issued the cycle after the first pulse.
    run_cmd(DIR_OUTER_TO_INNER, ADDR_Y1, 6'h10, acc);
    wait_pulse(pc1, found, e);
    chk("b2b_first_seen", found, 1);
    model_cmd(DIR_OUTER_TO_INNER, ADDR_Y1, 6'h10, N);
    run_cmd(DIR_OUTER_TO_INNER, ADDR_A, 6'h20, acc);
    chk("b2b_second_busy", busy, 1);
    wait_pulse(pc2, found, e);
    chk("b2b_second_seen", found, 1);
    chk("b2b_spacing", pc2 - pc1, 6);
    model_cmd(DIR_OUTER_TO_INNER, ADDR_A, 6'h20, N);
    sync();
    chk("b2b_mem", mem_diffs(), 0);

    // Command re-pulsed mid-transfer must be dropped silently.
    run_cmd(DIR_INNER_TO_OUTER, ADDR_PY, 6'h30, acc);
    cmd_transfer       = 1'b1;
    read_write_command = DIR_OUTER_TO_INNER;
    read_address       = 6'h00;
    write_address      = 6'h00;
    @(negedge clk);
    cmd_transfer = 1'b0;
    wait_pulse(pc, found, e);
    chk("ignore_lat", pc - acc, N + 1);
    repeat (8) @(negedge clk);
    sync();
    model_cmd(DIR_INNER_TO_OUTER, ADDR_PY, 6'h30, N);
    chk("ignore_mem", mem_diffs(), 0);
    chk_counts("ignore", DIR_INNER_TO_OUTER, N, N, 1);

    // Reset on the third XFER cycle: two words land, no pulse.
    run_cmd(DIR_OUTER_TO_INNER, 6'h12, 6'h2A, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    sync();
    model_cmd(DIR_OUTER_TO_INNER, 6'h12, 6'h2A, 2);
    chk("abort_mem", mem_diffs(), 0);
    chk_counts("abort", DIR_OUTER_TO_INNER, N, 2, 0);

    // Highest non-wrapping base, then a wrapping one.
    do_cmd("edge61", DIR_OUTER_TO_INNER, 61, 61);
    do_cmd("wrap62", DIR_OUTER_TO_INNER, 62, 62);
    do_cmd("wrap_wr", DIR_INNER_TO_OUTER, 7, 63);

    for (int i = 0; i < 8; i++) begin
      do_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end

    sync();
    chk("same_ram_rw", n_same, 0);
    chk("idle_hold", n_hold, 0);
`ifndef SCALAR_MUL_RAM_RANGE_CHECK_EN
    chk("xerr_tied", n_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_transfer_engine.md
RAM_TRANSFER_ENGINE -- requirements
Module: ram_transfer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of one RAM word.
REQ-002 SHALL have parameter WORDS_PER_OPERAND, default 3: words moved per command; operands sit at 3-word strides (3, 6, 9, 0x21, 0x27).
REQ-003 SHALL have the port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have the port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have the port cmd_transfer, input, 1: transfer request, sampled only in IDLE.
REQ-006 SHALL have the port read_write_command, input, 1: 0 = outer RAM to inner RAM, 1 = inner RAM to outer RAM.
REQ-007 SHALL have the port read_address, input, 6: source base address.
REQ-008 SHALL have the port write_address, input, 6: destination base address.
REQ-009 SHALL have the port interupt_ram_transfer, output, 1: one-cycle completion pulse.
REQ-010 SHALL have the port xfer_error, output, 1: one-cycle rejection pulse.
REQ-011 SHALL have the port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have the outer RAM ports outer_addr (output, 6), outer_rd_en (output, 1), outer_rdata (input, DATA_W), outer_wr_en (output, 1) and outer_wdata (output, DATA_W).
REQ-013 SHALL have the inner RAM ports inner_addr (output, 6), inner_rd_en (output, 1), inner_rdata (input, DATA_W), inner_wr_en (output, 1) and inner_wdata (output, DATA_W); both RAMs return read data one cycle after rd_en.

Function
REQ-014 SHALL implement the states IDLE, XFER and DONE.
REQ-015 SHALL, in IDLE with cmd_transfer=1, latch the direction and both base addresses, clear the word counter, and go to XFER.
REQ-016 SHALL pipeline the copy in XFER: cycle k (k=0..N-1, N=WORDS_PER_OPERAND) asserts source rd_en at base+k; cycle k+1 asserts destination wr_en at dst_base+k with the source rdata.
REQ-017 SHALL, for N=3, spend 4 cycles in XFER, then 1 cycle in DONE with interupt_ram_transfer=1, then return to IDLE; the pulse is on the 5th cycle after the accept edge.
REQ-018 SHALL be in IDLE on the cycle after the pulse, so a command issued in reaction to the pulse is accepted with no lost cycle.
REQ-019 SHALL ignore cmd_transfer in XFER and DONE; such a request is neither queued nor flagged.
REQ-020 SHALL compute addresses as 6-bit sums, so base+k wraps modulo 64 (subject to REQ-028).
REQ-021 SHALL drive all RAM enables low and hold addresses and write data stable whenever no access is made.
REQ-022 SHALL, for direction 0, read only outer RAM and write only inner RAM, and the converse for direction 1; it SHALL never assert rd_en and wr_en on the same RAM in one cycle.
REQ-023 SHALL copy correctly when source and destination base addresses are equal.

Reset
REQ-024 SHALL, on rst=1, enter IDLE on the next edge and drive every output to 0: both interrupts, busy, all enables, addresses and write data.
REQ-025 SHALL, on rst=1 mid-transfer, abort with no further RAM writes and no completion pulse; words already written remain.
REQ-026 SHALL give rst priority over cmd_transfer in the same cycle.

Configuration
REQ-027 SHALL use the macro SCALAR_MUL_RAM_RANGE_CHECK_EN to compile range checking in or out.
REQ-028 SHALL, when SCALAR_MUL_RAM_RANGE_CHECK_EN is defined, reject a command whose read_address or write_address exceeds 64-N: no RAM access, go directly to DONE, and pulse interupt_ram_transfer and xfer_error together on the cycle after the accept edge.
REQ-029 SHALL, when SCALAR_MUL_RAM_RANGE_CHECK_EN is undefined, tie xfer_error to 0 and wrap addresses as in REQ-020.

Structure
REQ-030 SHALL take DATA_W and WORDS_PER_OPERAND defaults, the state encoding, the direction constants DIR_OUTER_TO_INNER=0 and DIR_INNER_TO_OUTER=1, and the operand base addresses (X1=3, Y1=6, A=9, PX=0x21, PY=0x27) from the shared package scalar_mul_pkg.
REQ-031 SHALL be a single module; no sub-module is warranted.

Verification
REQ-032 SHALL test: outer words 3..5 = A,B,C; cmd dir=0 rd=3 wr=3 -> inner 3..5 = A,B,C; pulse exactly 5 cycles after the accept edge.
REQ-033 SHALL test: inner 0x21..0x23 loaded; cmd dir=1 rd=0x21 wr=0x21 -> outer holds the same data; inner_wr_en and outer_rd_en never asserted.
REQ-034 SHALL test: back-to-back commands, the second issued on the cycle after the pulse (rd=6, then rd=9) -> both accepted; pulses 6 cycles apart.
REQ-035 SHALL test: cmd_transfer re-pulsed during XFER -> ignored; exactly one pulse; no extra accesses.
REQ-036 SHALL test: rst=1 on the 3rd XFER cycle -> only words base and base+1 written; no pulse; all outputs 0 on the next cycle.
REQ-037 SHALL test: rd=62 -> with the macro, interrupt and xfer_error pulse 1 cycle after accept and no RAM access; without it, words 62, 63, 0 are copied.
